// File: rtl/game_flow_controller.sv
// Round sequencer: seat -> task -> door -> win, with a per-round countdown.
// Owns the HUD win/lose/round-count state and gates sprite movement.
//
// state      | meaning
// -----------+-----------------------------------------------
// IDLE       | power-up, waiting for start
// SEEK_SEAT  | player moving toward the target seat
// SEAT_DWELL | player in seat, dwell timer running
// TASK       | task overlay active, movement frozen
// SEEK_DOOR  | player moving toward the door
// DOOR_DWELL | player in door, dwell timer running
// WIN        | round won, waiting for start
// LOSE       | task failed or time expired, waiting for start
module game_flow_controller #(
  parameter int unsigned SEC_CYCLES   = 100_000_000,
  parameter int unsigned TIME_LIMIT   = 60,
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_seat,
  input  logic       in_door,
  input  logic       task_done,
  input  logic       task_fail,
  output logic       en,
  output logic       task_enable,
  output logic [2:0] state_code,
  output logic [5:0] seconds_left,
  output logic [3:0] round_count,
  output logic       win,
  output logic       lose
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int SW = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [SW-1:0] SEC_LAST   = SW'(SEC_CYCLES - 1);
  localparam logic [5:0]    TIME_INIT  = 6'(TIME_LIMIT);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SEEK_SEAT  = 3'd1,
    SEAT_DWELL = 3'd2,
    TASK       = 3'd3,
    SEEK_DOOR  = 3'd4,
    DOOR_DWELL = 3'd5,
    WIN        = 3'd6,
    LOSE       = 3'd7
  } state_t;

  state_t state, state_n;

  logic seat_m, seat_s, door_m, door_s;
  logic start_q, start_rise, start_edge;
  logic [DW-1:0] dwell_cnt;
  logic [SW-1:0] sec_cnt;
  logic timer_active, sec_tc, timeout, dwell_done;
  logic load_round, clr_rounds, inc_round;

  assign start_rise = start & ~start_q;

  // The detected start edge is registered so the FSM acts one edge after start_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seat_m     <= 1'b0;
      seat_s     <= 1'b0;
      door_m     <= 1'b0;
      door_s     <= 1'b0;
      start_q    <= 1'b0;
      start_edge <= 1'b0;
    end else begin
      seat_m     <= in_seat;
      seat_s     <= seat_m;
      door_m     <= in_door;
      door_s     <= door_m;
      start_q    <= start;
      start_edge <= start_rise;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  assign timer_active = (state == SEEK_SEAT) || (state == SEAT_DWELL) || (state == TASK) ||
                        (state == SEEK_DOOR) || (state == DOOR_DWELL);
  assign sec_tc     = (sec_cnt == SEC_LAST);
  assign timeout    = timer_active && sec_tc && (seconds_left == 6'd1);
  assign dwell_done = (dwell_cnt == DWELL_LAST);

  always_comb begin
    state_n    = state;
    load_round = 1'b0;
    clr_rounds = 1'b0;
    inc_round  = 1'b0;
    case (state)
      IDLE, WIN: begin
        if (start_edge) begin
          state_n    = SEEK_SEAT;
          load_round = 1'b1;
        end
      end
      LOSE: begin
        if (start_edge) begin
          state_n    = SEEK_SEAT;
          load_round = 1'b1;
          clr_rounds = 1'b1;
        end
      end
      SEEK_SEAT:  if (seat_s) state_n = SEAT_DWELL;
      SEAT_DWELL: begin
        if (!seat_s)         state_n = SEEK_SEAT;
        else if (dwell_done) state_n = TASK;
      end
      TASK: begin
        if (task_fail)      state_n = LOSE;
        else if (task_done) state_n = SEEK_DOOR;
      end
      SEEK_DOOR:  if (door_s) state_n = DOOR_DWELL;
      DOOR_DWELL: begin
        if (!door_s) begin
          state_n = SEEK_DOOR;
        end else if (dwell_done) begin
          state_n   = WIN;
          inc_round = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Running out of time beats any progress made on the same edge.
    if (timeout) begin
      state_n   = LOSE;
      inc_round = 1'b0;
    end
  end

  // Dwell count restarts whenever a dwell state is entered or left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_cnt <= '0;
    end else if (((state == SEAT_DWELL) || (state == DOOR_DWELL)) && (state_n == state)) begin
      dwell_cnt <= dwell_cnt + DW'(1);
    end else begin
      dwell_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_cnt      <= '0;
      seconds_left <= 6'd0;
    end else if (load_round) begin
      sec_cnt      <= '0;
      seconds_left <= TIME_INIT;
    end else if (timer_active) begin
      if (sec_tc) begin
        sec_cnt <= '0;
        if (seconds_left != 6'd0) seconds_left <= seconds_left - 6'd1;
      end else begin
        sec_cnt <= sec_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_count <= 4'd0;
    end else if (clr_rounds) begin
      round_count <= 4'd0;
    end else if (inc_round && (round_count != 4'd15)) begin
      round_count <= round_count + 4'd1;
    end
  end

  assign en          = (state == SEEK_SEAT) || (state == SEAT_DWELL) ||
                       (state == SEEK_DOOR) || (state == DOOR_DWELL);
  assign task_enable = (state == TASK);
  assign win         = (state == WIN);
  assign lose        = (state == LOSE);
  assign state_code  = state;

endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Round-sequencing FSM that sits directly downstream of the sprite movement controller. It consumes the controller's `in_seat` / `in_door` flags and drives its movement enable and task-overlay disable. It also owns the round countdown timer and the win/loss/round-count state shown by the HUD. The block advances the player through four phases in order: reach a target seat, complete the task, reach the door, win.

## Interface
Parameters:
- `SEC_CYCLES`, 100_000_000: `clk` cycles per countdown second.
- `TIME_LIMIT`, 60: seconds per round; must be in 1..63.
- `DWELL_CYCLES`, 50_000_000: cycles the player must stay continuously in a seat or door before it counts; must be ≥1.

Ports:
- `clk`  in  1  system clock (the fast board clock, not the slow movement clock).
- `rst`  in  1  reset; asynchronous and active-high.
- `start`  in  1  debounced button level; only rising edges act.
- `in_seat`  in  1  from the movement controller; registered in the slow clock domain, so synchronized here.
- `in_door`  in  1  same as `in_seat`.
- `task_done`  in  1  one-cycle pulse from the task controller.
- `task_fail`  in  1  one-cycle pulse from the task controller.
- `en`  out  1  movement/sprite enable.
- `task_enable`  out  1  drives `task_enable_switch` on the sprite controller.
- `state_code`  out  3  current state encoding.
- `seconds_left`  out  6  countdown value.
- `round_count`  out  4  rounds won since last loss/reset; saturates at 15.
- `win`  out  1  high while in the WIN state.
- `lose`  out  1  high while in the LOSE state.

## Operation
- `in_seat` and `in_door` each pass through a 2-flop synchronizer; the FSM uses only the synchronized `seat_s` / `door_s`.
- `start` is registered once; `start_rise` = `start & ~start_q`.
- States and encodings: IDLE=0, SEEK_SEAT=1, SEAT_DWELL=2, TASK=3, SEEK_DOOR=4, DOOR_DWELL=5, WIN=6, LOSE=7.
- Outputs are Moore, decoded from the state register only:
  - `en` is 1 in states 1, 2, 4 and 5.
  - `task_enable` is 1 in state 3.
  - `win` is 1 in state 6; `lose` is 1 in state 7.
  - `state_code` equals the state encoding.
- State transitions:
  - IDLE, WIN, LOSE: `start_rise` → SEEK_SEAT. On this transition, load `seconds_left` = `TIME_LIMIT` and clear the second counter. Leaving LOSE also clears `round_count`.
  - SEEK_SEAT: `seat_s` → SEAT_DWELL, with the dwell counter cleared.
  - SEAT_DWELL: if `seat_s` = 0, go to SEEK_SEAT. Otherwise the dwell counter increments; when it equals `DWELL_CYCLES`-1, go to TASK. Time in the state is therefore exactly `DWELL_CYCLES` cycles.
  - TASK: `task_fail` → LOSE, else `task_done` → SEEK_DOOR. If both are asserted in the same cycle, `task_fail` wins.
  - SEEK_DOOR and DOOR_DWELL mirror the seat pair using `door_s`. DOOR_DWELL completion → WIN and `round_count` += 1, saturating at 15.
- Countdown timer:
  - Active in states 1–5, including TASK.
  - The second counter counts 0..`SEC_CYCLES`-1. At terminal count it wraps to 0 and `seconds_left` decrements.
  - If that decrement takes `seconds_left` from 1 to 0, the next state is LOSE. This overrides every other transition in the same cycle, including dwell completion and `task_done`.
  - In states 0, 6 and 7 the timer holds; `seconds_left` keeps its last value.
- `start_rise` is ignored in states 1–5.
- Dwell counter width is clog2(`DWELL_CYCLES`), minimum 1. Second counter width is clog2(`SEC_CYCLES`).

## Timing
- Reset (asynchronous, effective immediately): state=IDLE, `en`=0, `task_enable`=0, `win`=0, `lose`=0, `state_code`=0, `seconds_left`=0, `round_count`=0. All counters, synchronizer flops and `start_q` are 0.
- Reset asserted mid-round aborts immediately to the values above; no partial round state survives.
- Sync latency: if `in_seat` rises before edge k, `seat_s` is high after edge k+1 and the state is SEAT_DWELL after edge k+2.
- Start latency: `start` rising before edge k gives `start_q` after edge k and SEEK_SEAT after edge k+1.
- Outputs change on the same edge as the state register; there is no further delay.
- `task_done` / `task_fail` are sampled unsynchronized; they must come from the `clk` domain.

## Test plan
All scenarios use `SEC_CYCLES`=10, `TIME_LIMIT`=3, `DWELL_CYCLES`=4.
- **Reset:** assert `rst` mid-SEAT_DWELL → all outputs 0 asynchronously, `state_code`=0 after release.
- **Happy path:** start; hold `in_seat`=1; pulse `task_done`; hold `in_door`=1 → states 1→2→3→4→5→6, `en` high except in TASK, `win`=1, `round_count`=1.
- **Dwell abort:** `in_seat` high for 3 cycles after sync, then low → returns to SEEK_SEAT with no TASK. Re-entry requires a full 4 fresh cycles.
- **Priority:** `task_done` and `task_fail` in the same cycle → LOSE. Restarting with `start` clears `round_count` to 0.
- **Timeout:** no movement after start → `seconds_left` reads 3, 2, 1 at 10-cycle intervals, then LOSE at cycle 30 with `seconds_left`=0. A timeout coinciding with DOOR_DWELL completion also gives LOSE.
- **Saturation and start filtering:** win 16 consecutive rounds → `round_count` stays 15. Holding `start` high through WIN does not start a new round until it is released and pressed again.
